// File: rtl/uart_rom_loader.sv
// uart_rom_loader
//   Boot-time program loader. Receives an 8N1 UART byte stream, reads a
//   16-bit little-endian word count, then assembles little-endian 32-bit
//   instruction words and writes each one into the instruction ROM with a
//   single-cycle strobe. Words past the end of the ROM are consumed but
//   not written. Once the declared number of words has been consumed the
//   loader raises a sticky done and ignores all further traffic.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   uart_rx    serial input, idles high, asynchronous to clk
//   rom_we     one-cycle ROM write strobe
//   rom_addr   word address of the write
//   rom_wdata  instruction word to write
//   busy       high from the first detected start bit until done
//   done       sticky, high once the last declared word is consumed
//   frame_err  sticky, set when any byte has a bad stop bit
module uart_rom_loader #(
  parameter int WAIT       = 3125,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam int               CNT_W   = $clog2(WAIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(WAIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(WAIT - 1);
  localparam logic [16:0]      DEPTH   = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LEN_LO, LEN_HI, WORD, DONE} ld_state_t;

  logic             rx_p0, rx_p1;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick;
  logic             byte_valid;

  ld_state_t        ld_state, ld_next;
  logic [15:0]      count;
  logic [15:0]      word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic             last_word;
  logic             zero_count;
  logic             last_slot;

  // Stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // tick marks the cycle in which the current bit is sampled
  always_comb begin
    rx_next = rx_state;
    tick    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_p1) rx_next = RX_START;
      RX_START: if (cnt == HALF_M1) begin
        tick    = 1'b1;
        rx_next = rx_p1 ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (cnt == FULL_M1) begin
        tick = 1'b1;
        if (bit_cnt == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP:  if (cnt == FULL_M1) begin
        tick    = 1'b1;
        rx_next = RX_IDLE;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Stage rx: bit timing, shift register, byte strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      cnt        <= (rx_state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
      if (tick && rx_state == RX_DATA) begin
        shreg   <= {rx_p1, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // shreg stays stable during the strobe cycle, so it doubles as byte data
      if (tick && rx_state == RX_STOP) begin
        if (rx_p1) byte_valid <= 1'b1;
        else       frame_err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_state <= LEN_LO;
    else       ld_state <= ld_next;
  end

  assign last_word  = ({1'b0, word_idx} + 17'd1) == {1'b0, count};
  assign zero_count = byte_valid && ld_state == LEN_HI && {shreg, count[7:0]} == 16'd0;

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LEN_LO: if (byte_valid) ld_next = LEN_HI;
      LEN_HI: if (byte_valid) ld_next = zero_count ? DONE : WORD;
      WORD:   if (byte_valid && byte_cnt == 2'd3 && last_word) ld_next = DONE;
      default: ld_next = DONE;
    endcase
  end

  // Stage ld: word assembly and registered ROM write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 16'd0;
      word_idx  <= 16'd0;
      byte_cnt  <= 2'd0;
      word_buf  <= 24'd0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= 32'd0;
      last_slot <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      last_slot <= 1'b0;
      if (rx_state == RX_IDLE && rx_next == RX_START && ld_state != DONE && !done)
        busy <= 1'b1;
      if (byte_valid) begin
        case (ld_state)
          LEN_LO: count[7:0]  <= shreg;
          LEN_HI: count[15:8] <= shreg;
          WORD: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= shreg;
              2'd1: word_buf[15:8]  <= shreg;
              2'd2: word_buf[23:16] <= shreg;
              default: begin
                // the write slot is used even when the address is past the ROM
                rom_we    <= {1'b0, word_idx} < DEPTH;
                rom_addr  <= word_idx[ADDR_WIDTH-1:0];
                rom_wdata <= {shreg, word_buf};
                word_idx  <= word_idx + 16'd1;
                last_slot <= last_word;
              end
            endcase
          end
          default: ;
        endcase
      end
      if (zero_count || last_slot) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

Boot-time program loader sitting upstream of the instruction ROM that the CPU fetches from. It receives an 8N1 UART byte stream on `uart_rx`, parses a 16-bit word-count header followed by little-endian 32-bit instruction words, and writes each word into the ROM through a single-cycle write strobe. The mother board holds the CPU in reset while `busy` is high and releases it on `done`.

## Interface
Parameters:
- `WAIT`, 3125: clock cycles per UART bit (CLOCK_HZ/baud); must be ≥ 4.
- `ADDR_WIDTH`, 10: ROM word-address width; ROM depth = 2**ADDR_WIDTH words.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high. Ports are named `clk` and `reset`, as elsewhere in the codebase.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `rom_we`  out  1  one-cycle ROM write strobe.
- `rom_addr`  out  ADDR_WIDTH  word address of the write.
- `rom_wdata`  out  32  instruction word to write.
- `busy`  out  1  high from the first detected start bit until `done`.
- `done`  out  1  sticky; high once the last header-declared word has been consumed.
- `frame_err`  out  1  sticky; set when any byte has a bad stop bit.

## Operation
- Input conditioning: 2-flop synchronizer on `uart_rx`. All decisions use the synchronized value.
- Bit-level receive FSM:
  - States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a synchronized falling edge (the line reads 0).
  - RX_START waits WAIT/2 cycles, then samples. A 0 starts RX_DATA. A 1 is treated as a glitch: return to RX_IDLE with no byte and no error.
  - RX_DATA samples 8 bits, one every WAIT cycles, LSB first.
  - RX_STOP samples after WAIT cycles:
    - 1: emit a one-cycle `byte_valid` with the byte.
    - 0: set `frame_err`, drop the byte.
  - Either way, return to RX_IDLE.
- Byte-level loader FSM:
  - States: LEN_LO, LEN_HI, WORD, DONE.
  - LEN_LO latches count[7:0]. LEN_HI latches count[15:8].
  - After LEN_HI: go to DONE if count == 0, else to WORD.
  - WORD assembles 4 bytes little-endian: first byte → [7:0], fourth → [31:24].
  - On the 4th byte: write the word, increment the word index, and clear the byte counter.
  - After word index reaches count: go to DONE.
  - DONE ignores all further UART traffic. `done` stays high and `rom_we` stays low until reset.
- Address rules:
  - `rom_addr` = word index, starting at 0.
  - Words with index ≥ 2**ADDR_WIDTH are consumed but not written (`rom_we` stays low). Counting continues to `count`.
- Dropped (frame-error) bytes do not advance any loader counter.
- `busy` rises on the first RX_START entry and falls when `done` rises.

## Timing
- Reset values:
  - Outputs: `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `busy`=0, `done`=0, `frame_err`=0.
  - Internal state: both FSMs idle, LEN_LO, all counters 0, synchronizer flops 1.
- Sampling: the start bit is sampled WAIT/2 cycles after detection. Data bit k is sampled WAIT·(k+1)+WAIT/2 cycles after detection. The stop bit is sampled at WAIT·9+WAIT/2.
- Write latency:
  - `byte_valid` is asserted in the cycle after the stop-bit sample.
  - `rom_we`, `rom_addr` and `rom_wdata` are registered and appear in the cycle after the 4th byte's `byte_valid`.
  - All three are valid together for exactly one cycle.
- Done timing:
  - `done` rises in the cycle after the final `rom_we` slot, whether or not the write was actually issued.
  - For count == 0, `done` rises in the cycle after LEN_HI's `byte_valid`.
- Back-to-back bytes (stop bit immediately followed by a start bit) must be received without loss.
- Reset mid-operation: everything returns to reset values immediately. A partially assembled word is discarded and is never written.

## Test plan
- **Single word** (WAIT=8): send bytes 01 00 13 05 A0 00 → exactly one `rom_we` pulse with `rom_addr`=0 and `rom_wdata`=32'h00A00513. `done`=1 one cycle later; `busy`=0; `frame_err`=0.
- **Three words back-to-back**: send header 03 00, then words 11111111, 22222222, 33333333 with no idle gaps → `rom_we` pulses at addr 0, 1, 2 with matching data. `done` only after the third pulse.
- **Frame error**: header 01 00, then one byte sent with its stop bit = 0, then 4 valid bytes 78 56 34 12 → `frame_err`=1 sticky. One write of 32'h12345678 at addr 0. `done`=1.
- **Glitch and zero count**: a 1-cycle low pulse on `uart_rx` produces no byte and no error. Then header 00 00 → `done`=1 with no `rom_we`. Later bytes are ignored.
- **Overflow** (ADDR_WIDTH=2): header 05 00 plus 5 words → 4 writes at addr 0–3. The 5th word is not written. `done` rises after the 5th word.
- **Reset mid-word**: header 02 00, 2 bytes, assert `reset` → all outputs 0 and no `rom_we`. A fresh single-word load afterwards succeeds at addr 0.
